// File: rtl/bandai_mapper_gen.sv
// Bandai 2003 cartridge mapper: unlock handshake, bank register file, ROM/SRAM decode.
// Define BANDAI_SO_EN to build the serial acknowledgement shifter; otherwise SO is tied high.
module bandai_mapper_gen #(
    parameter int                 ROM_BANKS   = 2,
    parameter int                 RADDR_W     = 7,
    parameter int                 SER_LEN     = 18,
    parameter logic [SER_LEN-1:0] SER_PATTERN = 18'h05140
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CEn,
    input  logic               SSn,
    input  logic               OEn,
    input  logic               WEn,
    input  logic [7:0]         ADDR,
    input  logic [7:0]         DQ_IN,
    output logic [7:0]         DQ_OUT,
    output logic               DQ_OE,
    output logic               SO,
    output logic               ROMCEn,
    output logic               RAMCEn,
    output logic [RADDR_W-1:0] RADDR
);
    localparam int         NREG        = ROM_BANKS + 2;
    localparam logic [7:0] REG_BASE    = 8'hC0;
    localparam logic [7:0] REG_LAST    = 8'(8'hC0 + NREG - 1);
    localparam logic [3:0] LAST_BANKED = 4'(1 + ROM_BANKS);

    typedef enum logic [1:0] {LOCK_A, LOCK_B, OPEN} state_t;

    state_t     state;
    logic       is_open;
    logic       unlock;
    logic [7:0] regs [NREG];
    logic [7:0] reg_idx;
    logic       ibr;
    logic       reg_wr;
    logic       reg_rd;
    logic [3:0] win;
    logic       rce;
    logic       ram_sel;
    logic       rom_sel;

    assign is_open = (state == OPEN);
    assign unlock  = (state == LOCK_B) && (ADDR == 8'hA5);

    // A repeated 5A keeps the handshake armed; anything else drops back to the start.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= LOCK_A;
        end else begin
            case (state)
                LOCK_A:  if (ADDR == 8'h5A) state <= LOCK_B;
                LOCK_B: begin
                    if (unlock)               state <= OPEN;
                    else if (ADDR != 8'h5A)   state <= LOCK_A;
                end
                OPEN:    state <= OPEN;
                default: state <= LOCK_A;
            endcase
        end
    end

    assign reg_idx = ADDR - REG_BASE;
    assign ibr     = (~CEn | ~SSn) & (ADDR >= REG_BASE) & (ADDR <= REG_LAST);
    assign reg_wr  = is_open & ibr & ~WEn & OEn;
    assign reg_rd  = is_open & ibr & ~OEn & WEn;

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) regs[i] <= 8'hFF;
        end else if (reg_wr) begin
            for (int i = 0; i < NREG; i++)
                if (reg_idx == 8'(i)) regs[i] <= DQ_IN;
        end
    end

    always_comb begin
        DQ_OUT = 8'h00;
        for (int i = 0; i < NREG; i++)
            if (reg_rd && reg_idx == 8'(i)) DQ_OUT = regs[i];
    end

    assign DQ_OE = reg_rd;

    assign win     = ADDR[7:4];
    assign rce     = is_open & SSn & ~CEn;
    assign ram_sel = rce & (win == 4'd1);
    assign rom_sel = rce & (win >= 4'd2);
    assign RAMCEn  = ~ram_sel;
    assign ROMCEn  = ~rom_sel;

    // Windows past the banked range map linearly, offset by reg0.
    always_comb begin
        RADDR = '0;
        if (ram_sel) begin
            RADDR = regs[1][RADDR_W-1:0];
        end else if (rom_sel) begin
            if (win > LAST_BANKED) begin
                RADDR = {regs[0][RADDR_W-5:0], win};
            end else begin
                for (int i = 2; i < NREG; i++)
                    if (win == 4'(i)) RADDR = regs[i][RADDR_W-1:0];
            end
        end
    end

`ifdef BANDAI_SO_EN
    logic [SER_LEN-1:0] shifter;
    logic [5:0]         bit_cnt;
    logic               shifting;

    // Ones fill in from the top, so once the pattern is drained SO rests high.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shifter  <= '1;
            bit_cnt  <= '0;
            shifting <= 1'b0;
        end else if (unlock) begin
            shifter  <= SER_PATTERN;
            bit_cnt  <= '0;
            shifting <= 1'b1;
        end else if (shifting) begin
            shifter <= SER_LEN'({1'b1, shifter} >> 1);
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == 6'(SER_LEN - 1)) shifting <= 1'b0;
        end
    end

    assign SO = shifter[0];
`else
    // SER_LEN is at least 1 for any legal build, so this is a constant high.
    assign SO = (SER_LEN > 0) || (SER_PATTERN == '0);
`endif

endmodule

// File: doc/bandai_mapper_gen.md
# bandai_mapper_gen

Parametrised cartridge mapper for the Bandai 2003 family. It gates access behind a two-address unlock handshake, emits a fixed serial acknowledgement bit-stream on SO once unlocked, and holds a register file of one linear-offset register, one RAM bank register and ROM_BANKS ROM bank registers. It drives the ROM/RAM chip selects and upper address lines. It sits between the console cartridge bus and the ROM/SRAM devices, and replaces the fixed two-ROM-bank mapper with a configurable window count and a split (non-tri-state) data bus.

## Interface
- ROM_BANKS, 2: number of banked ROM windows, 1..14; windows 2..1+ROM_BANKS are banked, the rest are linear.
- RADDR_W, 7: width of RADDR (device A15 upward), 5..8.
- SER_LEN, 18: length of the SO bit-stream, 1..32.
- SER_PATTERN, 18'h05140: bit-stream, shifted out LSB first.
- CLK  in  1  mapper clock, all state on the rising edge.
- RST  in  1  reset, synchronous, active-high.
- CEn  in  1  cartridge chip enable, active-low.
- SSn  in  1  system/IO select, active-low.
- OEn  in  1  output enable, active-low.
- WEn  in  1  write enable, active-low.
- ADDR  in  8  bus address bits {A18..A15, A3..A-1}; ADDR[7:4] is the window.
- DQ_IN  in  8  data from the bus.
- DQ_OUT  out  8  register readback data.
- DQ_OE  out  1  drive enable for DQ_OUT; the top level builds the tri-state.
- SO  out  1  serial acknowledgement output.
- ROMCEn  out  1  ROM chip enable, active-low.
- RAMCEn  out  1  SRAM chip enable, active-low.
- RADDR  out  RADDR_W  device upper address.

## Operation
- Unlock FSM states are LOCK_A, LOCK_B and OPEN. It samples ADDR on every CLK edge.
  - LOCK_A: ADDR==8'h5A -> LOCK_B; otherwise stay.
  - LOCK_B: ADDR==8'hA5 -> OPEN and load the shifter; ADDR==8'h5A -> stay; otherwise -> LOCK_A.
  - OPEN: terminal until RST; ADDR is no longer compared.
- Shifter: SER_LEN bits, loaded with SER_PATTERN on the LOCK_B->OPEN edge. It shifts right one bit per CLK with a 1 filled in at the MSB. SO is shifter[0].
  - A bit counter stops the shift after SER_LEN bits; SO then stays 1.
  - SO is 1 whenever the shifter is not loaded.
- Register file reg[0..ROM_BANKS+1] sits at ADDR 8'hC0+i. reg0 is the linear offset, reg1 the RAM bank, reg2.. the ROM banks. Each register is 8 bits.
  - Register select iBR = (~CEn | ~SSn) and ADDR in range.
  - Write: on a CLK edge with OPEN, iBR, WEn=0 and OEn=1, reg[ADDR-8'hC0] <= DQ_IN.
  - Read: when OPEN, iBR, OEn=0 and WEn=1, DQ_OE=1 and DQ_OUT=reg[ADDR-8'hC0]. This path is combinational.
  - DQ_OUT is 8'h00 when DQ_OE=0.
  - OEn=0 with WEn=0 gives neither a read nor a write.
- Memory decode uses rCE = OPEN & SSn & ~CEn.
  - RAMCEn = ~(rCE & ADDR[7:4]==1).
  - ROMCEn = ~(rCE & ADDR[7:4]>=2).
  - Window 0 asserts neither chip enable.
- RADDR, truncated or zero-extended to RADDR_W:
  - Window 1: reg1.
  - Window w in 2..1+ROM_BANKS: reg[w].
  - Window above 1+ROM_BANKS: {reg0[RADDR_W-5:0], ADDR[7:4]}.
  - When neither chip enable is asserted, RADDR=0.
- The register file is writable only in OPEN. Register writes never affect the FSM.

## Timing
- Reset values (the cycle after RST is sampled high):
  - FSM is LOCK_A; all registers are 8'hFF; shifter is all 1s; the counter is 0.
  - SO=1, DQ_OE=0, DQ_OUT=0, ROMCEn=1, RAMCEn=1, RADDR=0.
- Unlock latency: 8'h5A on edge n and 8'h5A or 8'hA5 on edge n+1 gives OPEN after edge n+1. The sequence 5A,5A,A5 is accepted.
- SO bit i (i=0..SER_LEN-1) is valid for the cycle after edge n+1+i. It is 1 from edge n+1+SER_LEN onward.
- Decode and readback take effect in the first cycle after reaching OPEN; both are combinational from ADDR and the strobes.
- A register write committed on edge k is visible on DQ_OUT and RADDR from cycle k+1.
- Writing the register currently selected by RADDR changes the bank with one cycle of latency. There is no glitch suppression.
- RST mid-stream aborts the shift (SO=1 next cycle), relocks the FSM and restores all registers to 8'hFF. RST has priority over every write.
- A write strobe held across several edges rewrites the same value on each edge. This is harmless.

## Configuration
- BANDAI_SO_EN defined: the shifter and bit counter are built and SO carries SER_PATTERN as specified.
- BANDAI_SO_EN undefined: the shifter is not built, SO is constant 1, and the unlock FSM and decode are unchanged.

## Test plan
- Reset then ADDR=0x5A, 0xA5: OPEN after the second edge; SO over 18 cycles = 0,0,0,0,0,0,1,0,1,0,0,0,1,0,1,0,0,0, then 1 steady.
- Locked write 0xC2<=0x3C, then unlock and read 0xC2: DQ_OE=1, DQ_OUT=0xFF. The write was ignored and no chip enable asserted before OPEN.
- ADDR sequence 5A,12,A5: the FSM returns to LOCK_A, stays locked and SO stays 1. Then 5A,5A,A5 unlocks.
- ROM_BANKS=2, OPEN: write C0<=0x05, C3<=0x11. Window 3 gives ROMCEn=0, RADDR=0x11; window 6 gives RADDR=0x56; window 1 gives RAMCEn=0, RADDR=0x7F.
- ROM_BANKS=4, RADDR_W=8: write C5<=0xA7. Window 5 gives RADDR=0xA7; readback of 0xC5 gives 0xA7; 0xC6 is not decoded (DQ_OE=0).
- RST asserted at SO bit 7: next cycle SO=1, the FSM is LOCK_A, 0xC1 reads 0xFF after re-unlock, and the stream restarts at bit 0.
